// File: rtl/turfio_cmd_serializer.sv
// Captures the spliced 32-bit rackbus command once per 8-clock frame and shifts it
// out MSB-first as eight nibbles, with training substitution, frame counting and sync checking.
module turfio_cmd_serializer #(
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A_6996
) (
    input  logic        sysclk_i,
    input  logic        rst_n_i,
    input  logic        sync_i,
    input  logic [31:0] spliced_i,
    input  logic        train_i,
    output logic [3:0]  cmd_o,
    output logic [2:0]  phase_o,
    output logic        capture_o,
    output logic        locked_o,
    output logic [15:0] frame_count_o,
    output logic [7:0]  misalign_count_o
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [31:0] shreg_q, shreg_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  misalign_q, misalign_d;

    logic        capture_cycle;
    logic        misaligned;
    logic [31:0] word;

    assign capture_cycle = (state_q == ST_LOCKED) && (phase_q == 3'd7);
    assign misaligned    = (state_q == ST_LOCKED) && sync_i && (phase_q != 3'd0);
    assign word          = train_i ? TRAIN_PATTERN : spliced_i;

    always_comb begin
        state_d    = state_q;
        phase_d    = sync_i ? 3'd1 : phase_q + 3'd1;
        shreg_d    = shreg_q;
        cmd_d      = cmd_q;
        frame_d    = frame_q;
        misalign_d = misalign_q;

        if (state_q == ST_UNLOCKED) begin
            cmd_d   = '0;
            shreg_d = '0;
            if (sync_i) begin
                state_d = ST_LOCKED;
            end
        end else if (misaligned) begin
            // A misaligned sync takes priority over capture: the aborted frame drains as zeros.
            cmd_d   = '0;
            shreg_d = '0;
            if (misalign_q != 8'hFF) begin
                misalign_d = misalign_q + 8'd1;
            end
        end else if (capture_cycle) begin
            cmd_d   = word[31:28];
            shreg_d = {word[27:0], 4'h0};
            frame_d = frame_q + 16'd1;
        end else begin
            cmd_d   = shreg_q[31:28];
            shreg_d = {shreg_q[27:0], 4'h0};
        end
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_UNLOCKED;
            phase_q    <= '0;
            shreg_q    <= '0;
            cmd_q      <= '0;
            frame_q    <= '0;
            misalign_q <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            cmd_q      <= cmd_d;
            frame_q    <= frame_d;
            misalign_q <= misalign_d;
        end
    end

    assign cmd_o            = cmd_q;
    assign phase_o          = phase_q;
    assign capture_o        = capture_cycle;
    assign locked_o         = (state_q == ST_LOCKED);
    assign frame_count_o    = frame_q;
    assign misalign_count_o = misalign_q;

endmodule
